md_sched_unit: RTL and testbench

//  Multi-cycle multiply/divide scheduler for the E stage, beside the ALU.

---
 rtl/md_sched_unit_pkg.sv | 40 ++++
 rtl/md_sched_unit_calc.sv | 52 +++++
 rtl/md_sched_unit.sv | 97 +++++++++
 tb/tb_md_sched_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_sched_unit_pkg.sv
// Shared MD op codes, FSM states and op-class helpers.
// MDU_MADD_EN enables the MADD/MADDU accumulate ops.
package md_sched_unit_pkg;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MADD  = 4'd7,
    MD_MADDU = 4'd8
  } md_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_e;

  function automatic logic md_is_div(
    input logic [3:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_multi(
    input logic [3:0] op
  );
    logic m;
    m = (op == MD_MULT) || (op == MD_MULTU) ||
        (op == MD_DIV)  || (op == MD_DIVU);
`ifdef MDU_MADD_EN
    m = m || (op == MD_MADD) || (op == MD_MADDU);
`endif
    return m;
  endfunction

endpackage

// File: rtl/md_sched_unit_calc.sv
// Combinational 64-bit MD result {hi,lo}; holds old HI/LO on divide by zero.
// MDU_MADD_EN adds the MADD/MADDU accumulate paths.
module md_calc
  import md_sched_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic [31:0]        q_s;
  logic [31:0]        r_s;
  logic               ovf;

  assign prod_s = $signed({{32{a[31]}}, a}) *
                  $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // -2^31 / -1 overflows 32 bits; pin the wrapped result
  assign ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

  always_comb begin
    q_s = 32'd0;
    r_s = 32'd0;
    if (b != 32'd0 && !ovf) begin
      q_s = $signed(a) / $signed(b);
      r_s = $signed(a) % $signed(b);
    end
    if (ovf) q_s = 32'h8000_0000;
  end

  always_comb begin
    res = {hi, lo};
    case (op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV:   if (b != 32'd0) res = {r_s, q_s};
      MD_DIVU:  if (b != 32'd0) res = {a % b, a / b};
`ifdef MDU_MADD_EN
      MD_MADD:  res = {hi, lo} + prod_s;
      MD_MADDU: res = {hi, lo} + prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/md_sched_unit.sv
// Multi-cycle MD scheduler: countdown latency, shadow result, HI/LO commit.
// MDU_MADD_EN enables MADD/MADDU (MULT_CYC latency).
module md_sched_unit
  import md_sched_unit_pkg::*;
#(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_d,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MC = 4'(MULT_CYC);
  localparam logic [3:0] DC = 4'(DIV_CYC);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] calc_res;
  logic        op_multi;

  md_calc u_calc (
    .op  (md_op),
    .a   (src_a),
    .b   (src_b),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc_res)
  );

  assign op_multi = md_is_multi(md_op);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (start && op_multi) begin
          res_d   = calc_res;
          cnt_d   = md_is_div(md_op) ? DC : MC;
          state_d = RUN;
        end else if (start && md_op == MD_MTHI) begin
          hi_d = src_a;
        end else if (start && md_op == MD_MTLO) begin
          lo_d = src_a;
        end
      end
      RUN: begin
        if (cnt_q == 4'd1) begin
          hi_d    = res_q[63:32];
          lo_d    = res_q[31:0];
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign md_stall = md_use_d & (busy | (start & op_multi));
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_md_sched_unit.sv
// Bench for md_sched_unit: directed cases then random ops vs a reference model.
// Honours MDU_MADD_EN the same way as the design.
module tb_md_sched_unit;
  import md_sched_unit_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_d;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;

  md_sched_unit #(.MULT_CYC(MC), .DIV_CYC(DC)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .md_op    (md_op),
    .src_a    (src_a),
    .src_b    (src_b),
    .md_use_d (md_use_d),
    .busy     (busy),
    .md_stall (md_stall),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int stall_cnt = 0;

  logic [31:0] m_hi, m_lo;
  logic [63:0] m_res;
  int          m_rem;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_multi(input logic [3:0] op);
    bit m;
    m = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`ifdef MDU_MADD_EN
    m = m || (op inside {MD_MADD, MD_MADDU});
`endif
    return m;
  endfunction

  function automatic logic [63:0] ref_result(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] h, input logic [31:0] l);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint unsigned ua = {32'd0, a};
    longint unsigned ub = {32'd0, b};
    longint q, r;
    longint unsigned uq, ur;
    logic [63:0] v;
    v = {h, l};
    case (op)
      MD_MULT:  v = 64'(sa * sb);
      MD_MULTU: v = 64'(ua * ub);
      MD_DIV: if (b != 0) begin
        q = sa / sb;
        r = sa % sb;
        v = {r[31:0], q[31:0]};
      end
      MD_DIVU: if (b != 0) begin
        uq = ua / ub;
        ur = ua % ub;
        v = {ur[31:0], uq[31:0]};
      end
      MD_MADD:  v = {h, l} + 64'(sa * sb);
      MD_MADDU: v = {h, l} + 64'(ua * ub);
      default:  v = {h, l};
    endcase
    return v;
  endfunction

  task automatic cycle(input bit st, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit use_d);
    bit exp_stall;
    @(negedge clk);
    start = st; md_op = op; src_a = a; src_b = b; md_use_d = use_d;
    #1;
    exp_stall = use_d && (m_rem > 0 || (st && ref_multi(op)));
    check("stall", 64'(md_stall), 64'(exp_stall));
    if (md_stall) stall_cnt++;
    @(posedge clk);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) {m_hi, m_lo} = m_res;
    end else if (st) begin
      if (ref_multi(op)) begin
        m_res = ref_result(op, a, b, m_hi, m_lo);
        m_rem = (op == MD_DIV || op == MD_DIVU) ? DC : MC;
      end else if (op == MD_MTHI) m_hi = a;
      else if (op == MD_MTLO) m_lo = a;
    end
    #1;
    check("busy", 64'(busy), 64'(m_rem > 0));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  endtask

  task automatic op_wait(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit use_d,
                         output int nb);
    cycle(1'b1, op, a, b, use_d);
    nb = busy ? 1 : 0;
    for (int i = 0; i < 20 && busy; i++) begin
      cycle(1'b0, MD_NONE, 32'd0, 32'd0, use_d);
      if (busy) nb++;
    end
  endtask

  int nb;
  logic [31:0] pick [6];

  initial begin
    pick[0] = 32'd0;          pick[1] = 32'hFFFF_FFFF;
    pick[2] = 32'h8000_0000;  pick[3] = 32'd1;
    pick[4] = 32'h7FFF_FFFF;  pick[5] = 32'd7;

    rst_n = 1'b0; start = 1'b0; md_op = MD_NONE;
    src_a = 32'd0; src_b = 32'd0; md_use_d = 1'b0;
    m_hi = 0; m_lo = 0; m_rem = 0; m_res = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    op_wait(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, nb);
    check("mult_cyc", 64'(nb), 64'd5);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    op_wait(MD_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0, nb);
    check("multu_cyc", 64'(nb), 64'd5);
    check("multu_hi", 64'(hi), 64'h0000_0002);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    op_wait(MD_DIV, -32'sd7, 32'd2, 1'b0, nb);
    check("div_cyc", 64'(nb), 64'd10);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);

    op_wait(MD_DIVU, 32'd7, 32'd0, 1'b0, nb);
    check("divz_cyc", 64'(nb), 64'd10);
    check("divz_hi", 64'(hi), 64'hFFFF_FFFF);
    check("divz_lo", 64'(lo), 64'hFFFF_FFFD);

    op_wait(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, nb);
    check("ovf_hi", 64'(hi), 64'd0);
    check("ovf_lo", 64'(lo), 64'h8000_0000);

    stall_cnt = 0;
    op_wait(MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1, nb);
    cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);
    check("stall_cnt", 64'(stall_cnt), 64'd6);

    cycle(1'b1, MD_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    cycle(1'b1, MD_MTHI, 32'h1234, 32'd0, 1'b0);
    for (int i = 0; i < 20 && busy; i++)
      cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    check("mthi_busy", 64'(hi), 64'hFFFF_FFFF);

    cycle(1'b1, MD_MTLO, 32'h55, 32'd0, 1'b1);
    check("mtlo", 64'(lo), 64'h55);

    cycle(1'b1, MD_DIV, 32'd100, 32'd7, 1'b0);
    repeat (6) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    m_hi = 0; m_lo = 0; m_rem = 0;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (12) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b0);
    check("no_commit", 64'({hi, lo}), 64'd0);

    cycle(1'b1, MD_MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0);
    cycle(1'b1, MD_MTHI, 32'd0, 32'd0, 1'b0);
    op_wait(MD_MADD, 32'd1, 32'd1, 1'b0, nb);
`ifdef MDU_MADD_EN
    check("madd_cyc", 64'(nb), 64'd5);
    check("madd_res", 64'({hi, lo}), 64'h1_0000_0000);
`else
    check("madd_cyc", 64'(nb), 64'd0);
    check("madd_res", 64'({hi, lo}), 64'h0000_0000_FFFF_FFFF);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)]
                                      : $urandom;
      b = ($urandom_range(0, 2) == 0) ? pick[$urandom_range(0, 5)]
                                      : $urandom;
      cycle($urandom_range(0, 2) != 0, 4'($urandom_range(0, 15)),
            a, b, 1'($urandom));
    end
    repeat (16) cycle(1'b0, MD_NONE, 32'd0, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
